master_spi: RTL and testbench
=============================

Name: master_spi

Overview:
- Synchronous SPI master; the upstream stage driving our 8-bit SPI slave's ss/sclk/mosi and consuming its miso.
- Accepts a byte on a start strobe, generates sclk from clk via a divider, shifts MSB-first in any of the 4 cpol/cpha modes, returns the received byte with a done pulse.
- Single clock domain: the slave samples sclk/mosi/ss synchronously on the same clk.

Parameters:
- DATA_W, 8, transfer length in bits; MSB first.
- CLK_DIV, 4, sclk half-period in clk cycles; legal range >=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  transfer request; accepted only in IDLE.
- cpol  in  1  sclk idle level; latched on accept.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accept.
- data_in  in  DATA_W  byte to transmit; latched on accept.
- miso  in  1  serial data from slave.
- sclk  out  1  serial clock.
- mosi  out  1  serial data to slave.
- ss  out  1  slave select, active-low.
- busy  out  1  high from the accept cycle until return to IDLE.
- done  out  1  one-cycle pulse at transfer end.
- data_out  out  DATA_W  received byte; valid from the done cycle, held until next done.

Behaviour:
- Reset: sclk=0, mosi=0, ss=1, busy=0, done=0, data_out=0, state=IDLE, counters=0. rst wins over every other input, including mid-transfer: ss goes 1 on the next edge and the partial byte is discarded.
- IDLE: sclk follows the live cpol input, registered. When start=1: latch data_in into tx shift register, latch cpol/cpha, clear rx register, go to SETUP. Next cycle: ss=0, busy=1, mosi=data_in[DATA_W-1].
- SETUP: lasts CLK_DIV cycles; sclk held at latched cpol; then XFER.
- XFER: a divider counts CLK_DIV cycles per half-period. At each terminal count, sclk toggles and an edge action runs; there are 2*DATA_W edges in total.
  - Odd edges (leading): cpha=0 samples miso into rx LSB; cpha=1 shifts tx and drives the next bit (the first leading edge drives the MSB).
  - Even edges (trailing): cpha=0 shifts tx and drives the next bit; cpha=1 samples miso.
  - After edge 2*DATA_W, sclk equals cpol again; go to HOLD.
- HOLD: CLK_DIV cycles with ss=0 and sclk=cpol, then IDLE.
  - On that transition: ss=1, busy=0, done=1, data_out=rx, all in the same cycle.
- Latency: busy high for exactly CLK_DIV*(2*DATA_W+2) cycles, i.e. 72 at defaults. done is asserted on the cycle busy falls.
- start while busy: ignored, with no queueing.
- start=1 in the done cycle: state is IDLE, so it is accepted; back-to-back transfers have 1 cycle of ss high.
- cpol/cpha/data_in changes during a transfer: no effect.
- CLK_DIV=1: sclk toggles every clk cycle and sclk = clk/2; must be functional.

Decomposition:
- Package spi_pkg:
  - state encoding IDLE/SETUP/XFER/HOLD (2 bits);
  - mode constants MODE0..MODE3 as {cpol,cpha};
  - DATA_W default.
- Sub-module spi_clk_gen (params CLK_DIV): inputs clk, rst, run; outputs sclk level, lead_stb, trail_stb, edge count.
- Top holds the FSM, shift registers and handshake.

Test Plan:
- Mode 0, miso looped to mosi, data_in=0xA5, start at T0 -> ss falls at T0+1; data_out=0xA5 and done=1 at T0+72; 16 sclk edges; sclk idle 0.
- Mode 3 with a behavioural slave returning 0x3C, data_in=0xC3 -> slave receives 0xC3, data_out=0x3C; sclk idles 1 before and after; sampling occurs on rising edges.
- Modes 1 and 2, data_in=0x81, loopback -> data_out=0x81; mosi changes only on the drive edge, stable at each sample edge.
- start pulsed at T0+10 during busy with data_in=0xFF -> ignored; data_out = first byte; a single done pulse.
- rst asserted at T0+30 -> next cycle ss=1, busy=0, sclk=0, data_out=0, no done. A new start after release completes normally.
- CLK_DIV=1, start held high continuously, data 0x00 then 0xFF -> two transfers of 18 cycles each, ss high for 1 cycle between them, done pulses at both ends.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master
package spi_pkg;

  // Default transfer length in bits
  localparam int DATA_W_DEF = 8;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // SPI modes as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - sclk divider with leading/trailing edge strobes
module spi_clk_gen #(
  parameter int CLK_DIV = 4,
  parameter int EDGES   = 16,
  parameter int EDGE_W  = $clog2(EDGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              idle_lvl_i,
  output logic              sclk_o,
  output logic              lead_stb_o,
  output logic              trail_stb_o,
  output logic [EDGE_W-1:0] edge_cnt_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              lvl_q, lvl_d;
  logic              term;

  // Half-period counter; the strobes fire in the cycle before sclk toggles
  always_comb begin
    term   = run_i && (div_q == DIV_LAST);
    div_d  = div_q;
    edge_d = edge_q;
    lvl_d  = lvl_q;
    if (!run_i) begin
      div_d  = '0;
      edge_d = '0;
      lvl_d  = idle_lvl_i;
    end else if (term) begin
      div_d  = '0;
      edge_d = edge_q + EDGE_W'(1);
      lvl_d  = ~lvl_q;
    end else begin
      div_d  = div_q + CNT_W'(1);
    end
  end

  // Divider, edge counter and sclk level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      edge_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
      lvl_q  <= lvl_d;
    end
  end

  // Even count means the upcoming edge is odd-numbered (leading)
  assign lead_stb_o  = term && !edge_q[0];
  assign trail_stb_o = term &&  edge_q[0];
  assign sclk_o      = lvl_q;
  assign edge_cnt_o  = edge_q;

endmodule

// File: rtl/master_spi.sv
// rtl/master_spi.sv - SPI master: FSM, shift registers and start/done handshake
module master_spi
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              ss,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);

  localparam int EDGES  = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  PH_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  ph_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              mosi_q;
  logic              ss_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] dout_q;

  logic              run;
  logic              idle_lvl;
  logic              lead_stb;
  logic              trail_stb;
  logic [EDGE_W-1:0] edge_cnt;

  // In IDLE sclk tracks the live cpol so the bus already idles correctly at accept
  assign run      = (state_q == ST_XFER);
  assign idle_lvl = (state_q == ST_IDLE) ? cpol : cpol_q;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .EDGES   (EDGES),
    .EDGE_W  (EDGE_W)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run),
    .idle_lvl_i  (idle_lvl),
    .sclk_o      (sclk),
    .lead_stb_o  (lead_stb),
    .trail_stb_o (trail_stb),
    .edge_cnt_o  (edge_cnt)
  );

  // Transfer FSM with registered bus and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tx_q    <= data_in;
            rx_q    <= '0;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            mosi_q  <= data_in[DATA_W-1];
            ss_q    <= 1'b0;
            busy_q  <= 1'b1;
            ph_q    <= '0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_q == PH_LAST) begin
            ph_q    <= '0;
            state_q <= ST_XFER;
          end else begin
            ph_q <= ph_q + CNT_W'(1);
          end
        end
        ST_XFER: begin
          if (lead_stb) begin
            if (!cpha_q) begin
              rx_q <= {rx_q[DATA_W-2:0], miso};
            end else if (edge_cnt != '0) begin
              // The first leading edge presents the MSB already on mosi
              tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
              mosi_q <= tx_q[DATA_W-2];
            end
          end
          if (trail_stb) begin
            if (!cpha_q) begin
              tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
              mosi_q <= tx_q[DATA_W-2];
            end else begin
              rx_q <= {rx_q[DATA_W-2:0], miso};
            end
            if (edge_cnt == EDGE_LAST) begin
              ph_q    <= '0;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (ph_q == PH_LAST) begin
            ph_q    <= '0;
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dout_q  <= rx_q;
            state_q <= ST_IDLE;
          end else begin
            ph_q <= ph_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mosi     = mosi_q;
  assign ss       = ss_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_master_spi.sv
// tb/tb_master_spi.sv - self-checking bench for master_spi
module tb_master_spi;
  import spi_pkg::*;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] sbyte;
    bit         loop;
    logic [7:0] exp_out;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, cpol_a, cpha_a, miso_a, sclk_a, mosi_a, ss_a, busy_a, done_a;
  logic [7:0] din_a, dout_a;
  logic       start_b, cpol_b, cpha_b, miso_b, sclk_b, mosi_b, ss_b, busy_b, done_b;
  logic [7:0] din_b, dout_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural slave for instance A
  bit         loop_a;
  logic [7:0] s_tx, s_rx, slave_byte;
  assign miso_a = loop_a ? mosi_a : s_tx[7];
  assign miso_b = mosi_b;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int edges_a, mosi_bad, done_cnt_a, done_cnt_b;
  logic sclk_p, mosi_p, ss_p;

  master_spi #(.DATA_W(8), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cpol(cpol_a), .cpha(cpha_a),
    .data_in(din_a), .miso(miso_a), .sclk(sclk_a), .mosi(mosi_a), .ss(ss_a),
    .busy(busy_a), .done(done_a), .data_out(dout_a)
  );

  master_spi #(.DATA_W(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cpol(cpol_b), .cpha(cpha_b),
    .data_in(din_b), .miso(miso_b), .sclk(sclk_b), .mosi(mosi_b), .ss(ss_b),
    .busy(busy_b), .done(done_b), .data_out(dout_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave model, bus monitor and scoreboard for instance A
  always @(negedge clk) begin
    if (ss_a) begin
      s_tx = slave_byte;
    end else if (sclk_a != sclk_p) begin
      edges_a++;
      if (sclk_a == (cpol_a == cpha_a)) begin
        s_rx = {s_rx[6:0], mosi_a};
        s_tx = {s_tx[6:0], 1'b0};
      end
    end
    if (!ss_a && !ss_p && mosi_a != mosi_p) begin
      if (!(sclk_a != sclk_p && sclk_a != (cpol_a == cpha_a))) mosi_bad++;
    end
    if (done_a) begin
      done_cnt_a++;
      if (q_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_done: got done with data %0h expected no done", dout_a);
      end else begin
        check("a_data_out", dout_a, q_a.pop_front());
      end
    end
    sclk_p = sclk_a;
    mosi_p = mosi_a;
    ss_p   = ss_a;
  end

  // scoreboard for instance B
  always @(negedge clk) begin
    if (done_b) begin
      done_cnt_b++;
      if (q_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_done: got done with data %0h expected no done", dout_b);
      end else begin
        check("b_data_out", dout_b, q_b.pop_front());
      end
    end
  end

  task automatic wait_done_a(input string tag, output int t);
    bit got;
    got = 0;
    t = cyc;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_a) begin
        got = 1;
        t = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1);
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int t0, t1, dc0;
    cpol_a = v.mode[1];
    cpha_a = v.mode[0];
    loop_a = v.loop;
    slave_byte = v.sbyte;
    din_a = v.din;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_idle_sclk"}, sclk_a, v.mode[1]);
    @(negedge clk);
    start_a = 1'b1;
    edges_a = 0;
    mosi_bad = 0;
    dc0 = done_cnt_a;
    @(posedge clk); #1;
    t0 = cyc;
    start_a = 1'b0;
    q_a.push_back(v.exp_out);
    check({tag, "_ss_low"}, ss_a, 0);
    check({tag, "_busy"}, busy_a, 1);
    check({tag, "_mosi_msb"}, mosi_a, v.din[7]);
    wait_done_a(tag, t1);
    check({tag, "_latency"}, t1 - t0, 72);
    check({tag, "_ss_high"}, ss_a, 1);
    check({tag, "_busy_low"}, busy_a, 0);
    check({tag, "_edges"}, edges_a, 16);
    check({tag, "_mosi_stable"}, mosi_bad, 0);
    check({tag, "_slave_rx"}, s_rx, v.din);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_sclk_after"}, sclk_a, v.mode[1]);
    check({tag, "_done_count"}, done_cnt_a - dc0, 1);
  endtask

  vec_t vecs[5];

  initial begin
    int t0, t1, dc0, acc1, acc2, d1, d2;
    bit got;

    vecs[0] = '{MODE0, 8'hA5, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{MODE3, 8'hC3, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{MODE1, 8'h81, 8'h00, 1'b1, 8'h81};
    vecs[3] = '{MODE2, 8'h81, 8'h00, 1'b1, 8'h81};
    vecs[4] = '{MODE0, 8'h5A, 8'h96, 1'b0, 8'h96};

    rst = 1'b1;
    start_a = 0; cpol_a = 1'b1; cpha_a = 0; din_a = '0; loop_a = 1; slave_byte = '0;
    start_b = 0; cpol_b = 0; cpha_b = 0; din_b = '0;
    s_tx = '0; s_rx = '0; sclk_p = 0; mosi_p = 0; ss_p = 1;
    edges_a = 0; mosi_bad = 0; done_cnt_a = 0; done_cnt_b = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", sclk_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_ss", ss_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_data_out", dout_a, 0);
    check("rst_ss_b", ss_b, 1);
    rst = 1'b0;

    // vector table across the four modes
    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // start during busy is ignored
    cpol_a = 0; cpha_a = 0; loop_a = 1; din_a = 8'h3E;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1;
    dc0 = done_cnt_a;
    @(posedge clk); #1;
    t0 = cyc;
    start_a = 1'b0;
    q_a.push_back(8'h3E);
    repeat (9) @(posedge clk);
    #1;
    start_a = 1'b1;
    din_a = 8'hFF;
    @(posedge clk); #1;
    check("busy_start_busy", busy_a, 1);
    start_a = 1'b0;
    din_a = 8'h3E;
    wait_done_a("busy_start", t1);
    check("busy_start_latency", t1 - t0, 72);
    repeat (100) @(posedge clk);
    #1;
    check("busy_start_single_done", done_cnt_a - dc0, 1);
    check("busy_start_data", dout_a, 8'h3E);

    // reset mid-transfer
    cpol_a = 1; cpha_a = 0; loop_a = 1; din_a = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1;
    dc0 = done_cnt_a;
    @(posedge clk); #1;
    start_a = 1'b0;
    q_a.push_back(8'h5A);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ss", ss_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_sclk", sclk_a, 0);
    check("midrst_data_out", dout_a, 0);
    check("midrst_done", done_a, 0);
    rst = 1'b0;
    q_a.delete();
    repeat (100) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt_a - dc0, 0);
    run_xfer('{MODE0, 8'h69, 8'h00, 1'b1, 8'h69}, "after_rst");

    // CLK_DIV=1 back-to-back with start held high
    din_b = 8'h00;
    @(negedge clk);
    start_b = 1'b1;
    q_b.push_back(8'h00);
    @(posedge clk); #1;
    acc1 = cyc;
    check("b_ss_low1", ss_b, 0);
    din_b = 8'hFF;
    got = 0;
    d1 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_b) begin
        got = 1;
        d1 = cyc;
        break;
      end
    end
    check("b_done1_seen", got, 1);
    check("b_latency1", d1 - acc1, 18);
    check("b_ss_gap", ss_b, 1);
    q_b.push_back(8'hFF);
    @(posedge clk); #1;
    acc2 = cyc;
    start_b = 1'b0;
    check("b_ss_low2", ss_b, 0);
    check("b_busy2", busy_b, 1);
    check("b_mosi_msb2", mosi_b, 1);
    got = 0;
    d2 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_b) begin
        got = 1;
        d2 = cyc;
        break;
      end
    end
    check("b_done2_seen", got, 1);
    check("b_latency2", d2 - acc2, 18);
    repeat (30) @(posedge clk);
    #1;
    check("b_done_count", done_cnt_b, 2);
    check("b_ss_idle", ss_b, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
